// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file write port, with a pending-write scoreboard.
// Optional WB_BYPASS_EN adds registered same-edge write bypass outputs for two read ports.
module regfile_wb_arbiter #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [AW-1:0]     a_addr,
  input  logic [DW-1:0]     a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [AW-1:0]     b_addr,
  input  logic [DW-1:0]     b_data,
  input  logic              claim_valid,
  input  logic [AW-1:0]     claim_addr,
`ifdef WB_BYPASS_EN
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic              byp1_hit,
  output logic              byp2_hit,
  output logic [DW-1:0]     byp_data,
`endif
  output logic              we,
  output logic [AW-1:0]     wa,
  output logic [DW-1:0]     wd,
  output logic [2**AW-1:0]  pend_mask,
  output logic              err
);

  typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;

  grant_e             last_grant;
  logic               xfer;
  logic [AW-1:0]      g_addr;
  logic [DW-1:0]      g_data;
  logic [2**AW-1:0]   pend_next;
  logic               claim_hit;

  // Ready looks only at the valids and last_grant, never at the other ready.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      a_ready = a_valid && (!b_valid || last_grant == GRANT_B);
      b_ready = b_valid && (!a_valid || last_grant == GRANT_A);
    end
  end

  always_comb begin
    xfer   = (a_valid && a_ready) || (b_valid && b_ready);
    g_addr = a_ready ? a_addr : b_addr;
    g_data = a_ready ? a_data : b_data;
  end

  // Clear applied before set so a same-cycle claim supersedes the retiring write.
  always_comb begin
    pend_next = pend_mask;
    if (xfer)
      pend_next[g_addr] = 1'b0;
    if (claim_valid)
      pend_next[claim_addr] = 1'b1;
    claim_hit = claim_valid && (claim_addr == g_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_B;
      we         <= 1'b0;
      wa         <= '0;
      wd         <= '0;
      pend_mask  <= '0;
      err        <= 1'b0;
    end else begin
      we        <= xfer;
      pend_mask <= pend_next;
      if (xfer) begin
        wa         <= g_addr;
        wd         <= g_data;
        last_grant <= a_ready ? GRANT_A : GRANT_B;
        if (!pend_mask[g_addr] && !claim_hit)
          err <= 1'b1;
      end
    end
  end

`ifdef WB_BYPASS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      byp1_hit <= 1'b0;
      byp2_hit <= 1'b0;
      byp_data <= '0;
    end else begin
      byp1_hit <= we && (wa == ra1);
      byp2_hit <= we && (wa == ra2);
      byp_data <= wd;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; bypass checks compiled in with WB_BYPASS_EN.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [3:0]  a_addr, b_addr, claim_addr, wa;
  logic [15:0] a_data, b_data, wd, pend_mask;
  logic        claim_valid, we, err;
`ifdef WB_BYPASS_EN
  logic [3:0]  ra1, ra2;
  logic        byp1_hit, byp2_hit;
  logic [15:0] byp_data;
`endif

  int vecs = 0;
  int miss = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DW(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .claim_valid(claim_valid), .claim_addr(claim_addr),
`ifdef WB_BYPASS_EN
    .ra1(ra1), .ra2(ra2), .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp_data(byp_data),
`endif
    .we(we), .wa(wa), .wd(wd), .pend_mask(pend_mask), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; claim_valid = 0;
    a_addr = 0; b_addr = 0; claim_addr = 0; a_data = 0; b_data = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (3) tick();
    vecs++; if (we !== 1'b0) begin miss++; $display("FAIL reset_we got=%b exp=0", we); end
    vecs++; if (wa !== 4'h0) begin miss++; $display("FAIL reset_wa got=%h exp=0", wa); end
    vecs++; if (wd !== 16'h0) begin miss++; $display("FAIL reset_wd got=%h exp=0000", wd); end
    vecs++; if (pend_mask !== 16'h0) begin miss++; $display("FAIL reset_pend got=%h exp=0000", pend_mask); end
    vecs++; if (err !== 1'b0) begin miss++; $display("FAIL reset_err got=%b exp=0", err); end
    vecs++; if ({a_ready, b_ready} !== 2'b00) begin miss++; $display("FAIL reset_ready got=%b exp=00", {a_ready, b_ready}); end
  endtask

  task automatic test_single();
    claim_valid = 1; claim_addr = 3;
    tick();
    claim_valid = 0;
    vecs++; if (pend_mask !== 16'h0008) begin miss++; $display("FAIL single_claim got=%h exp=0008", pend_mask); end
    a_valid = 1; a_addr = 3; a_data = 16'h1234;
    #1;
    vecs++; if ({a_ready, b_ready} !== 2'b10) begin miss++; $display("FAIL single_ready got=%b exp=10", {a_ready, b_ready}); end
    tick();
    a_valid = 0;
    vecs++; if ({we, wa, wd} !== {1'b1, 4'h3, 16'h1234}) begin miss++; $display("FAIL single_write got=%b/%h/%h exp=1/3/1234", we, wa, wd); end
    vecs++; if (pend_mask !== 16'h0) begin miss++; $display("FAIL single_pend got=%h exp=0000", pend_mask); end
    vecs++; if (err !== 1'b0) begin miss++; $display("FAIL single_err got=%b exp=0", err); end
    tick();
    vecs++; if ({we, wa, wd} !== {1'b0, 4'h3, 16'h1234}) begin miss++; $display("FAIL single_hold got=%b/%h/%h exp=0/3/1234", we, wa, wd); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    claim_valid = 1; claim_addr = 5;
    tick();
    claim_addr = 6;
    tick();
    claim_valid = 0;
    vecs++; if (pend_mask !== 16'h0060) begin miss++; $display("FAIL b2b_claim got=%h exp=0060", pend_mask); end
    a_valid = 1; a_addr = 5; a_data = 16'hAAAA;
    b_valid = 1; b_addr = 6; b_data = 16'hBBBB;
    #1;
    vecs++; if ({a_ready, b_ready} !== 2'b10) begin miss++; $display("FAIL b2b_grant1 got=%b exp=10", {a_ready, b_ready}); end
    tick();
    vecs++; if ({we, wa, wd} !== {1'b1, 4'h5, 16'hAAAA}) begin miss++; $display("FAIL b2b_write1 got=%b/%h/%h exp=1/5/aaaa", we, wa, wd); end
    vecs++; if ({a_ready, b_ready} !== 2'b01) begin miss++; $display("FAIL b2b_grant2 got=%b exp=01", {a_ready, b_ready}); end
    a_valid = 0;
    tick();
    b_valid = 0;
    vecs++; if ({we, wa, wd} !== {1'b1, 4'h6, 16'hBBBB}) begin miss++; $display("FAIL b2b_write2 got=%b/%h/%h exp=1/6/bbbb", we, wa, wd); end
    vecs++; if ({pend_mask, err} !== {16'h0, 1'b0}) begin miss++; $display("FAIL b2b_pend_err got=%h/%b exp=0000/0", pend_mask, err); end
    // last_grant is B now, so contention must favour A; valids drop before the edge
    a_valid = 1; b_valid = 1;
    #1;
    vecs++; if ({a_ready, b_ready} !== 2'b10) begin miss++; $display("FAIL b2b_lastgrant got=%b exp=10", {a_ready, b_ready}); end
    a_valid = 0; b_valid = 0;
    #1;
    vecs++; if ({a_ready, b_ready} !== 2'b00) begin miss++; $display("FAIL idle_ready got=%b exp=00", {a_ready, b_ready}); end
    tick();
    vecs++; if (we !== 1'b0) begin miss++; $display("FAIL b2b_idle_we got=%b exp=0", we); end
  endtask

  task automatic test_same_dest();
    // last_grant=B: A first; the claim alongside A's write re-pends reg 4 for B
    claim_valid = 1; claim_addr = 4;
    tick();
    a_valid = 1; a_addr = 4; a_data = 16'h1111;
    b_valid = 1; b_addr = 4; b_data = 16'h2222;
    tick();
    claim_valid = 0;
    vecs++; if ({we, wa, wd} !== {1'b1, 4'h4, 16'h1111}) begin miss++; $display("FAIL same_w1 got=%b/%h/%h exp=1/4/1111", we, wa, wd); end
    vecs++; if (pend_mask !== 16'h0010) begin miss++; $display("FAIL same_setwins got=%h exp=0010", pend_mask); end
    a_valid = 0;
    tick();
    b_valid = 0;
    vecs++; if ({we, wa, wd} !== {1'b1, 4'h4, 16'h2222}) begin miss++; $display("FAIL same_w2 got=%b/%h/%h exp=1/4/2222", we, wa, wd); end
    vecs++; if ({pend_mask, err} !== {16'h0, 1'b0}) begin miss++; $display("FAIL same_pend_err got=%h/%b exp=0000/0", pend_mask, err); end
  endtask

  task automatic test_claim_set();
    claim_valid = 1; claim_addr = 10;
    tick();
    tick();
    claim_valid = 0;
    vecs++; if ({pend_mask, err} !== {16'h0400, 1'b0}) begin miss++; $display("FAIL reclaim got=%h/%b exp=0400/0", pend_mask, err); end
    b_valid = 1; b_addr = 9; b_data = 16'h00FF;
    claim_valid = 1; claim_addr = 9;
    #1;
    vecs++; if (b_ready !== 1'b1) begin miss++; $display("FAIL collide_ready got=%b exp=1", b_ready); end
    tick();
    b_valid = 0; claim_valid = 0;
    vecs++; if ({we, wa, wd} !== {1'b1, 4'h9, 16'h00FF}) begin miss++; $display("FAIL collide_write got=%b/%h/%h exp=1/9/00ff", we, wa, wd); end
    vecs++; if ({pend_mask, err} !== {16'h0600, 1'b0}) begin miss++; $display("FAIL collide_pend got=%h/%b exp=0600/0", pend_mask, err); end
  endtask

  task automatic test_err();
    apply_reset();
    a_valid = 1; a_addr = 7; a_data = 16'h0001;
    tick();
    a_valid = 0;
    vecs++; if ({we, wa, err} !== {1'b1, 4'h7, 1'b1}) begin miss++; $display("FAIL err_set got=%b/%h/%b exp=1/7/1", we, wa, err); end
    repeat (3) tick();
    vecs++; if (err !== 1'b1) begin miss++; $display("FAIL err_sticky got=%b exp=1", err); end
    apply_reset();
    vecs++; if (err !== 1'b0) begin miss++; $display("FAIL err_rst got=%b exp=0", err); end
  endtask

  task automatic test_reset_mid();
    claim_valid = 1; claim_addr = 1;
    tick();
    claim_valid = 0;
    a_valid = 1; a_addr = 1; a_data = 16'h5555;
    rst = 1;
    #1;
    vecs++; if (a_ready !== 1'b0) begin miss++; $display("FAIL rstmid_ready got=%b exp=0", a_ready); end
    tick();
    rst = 0; a_valid = 0;
    vecs++; if ({we, pend_mask, err} !== {1'b0, 16'h0, 1'b0}) begin miss++; $display("FAIL rstmid_state got=%b/%h/%b exp=0/0000/0", we, pend_mask, err); end
  endtask

`ifdef WB_BYPASS_EN
  task automatic test_bypass();
    ra1 = 2; ra2 = 4;
    claim_valid = 1; claim_addr = 2;
    tick();
    claim_valid = 0;
    a_valid = 1; a_addr = 2; a_data = 16'hCAFE;
    tick();
    a_valid = 0;
    tick();
    vecs++; if ({byp1_hit, byp2_hit, byp_data} !== {1'b1, 1'b0, 16'hCAFE}) begin miss++; $display("FAIL bypass got=%b/%b/%h exp=1/0/cafe", byp1_hit, byp2_hit, byp_data); end
    tick();
    vecs++; if ({byp1_hit, byp2_hit} !== 2'b00) begin miss++; $display("FAIL bypass_idle got=%b exp=00", {byp1_hit, byp2_hit}); end
  endtask
`endif

  initial begin
    rst = 1;
    idle_inputs();
`ifdef WB_BYPASS_EN
    ra1 = 0; ra2 = 0;
`endif
    test_reset();
    test_single();
    test_back_to_back();
    test_same_dest();
    test_claim_set();
    test_err();
    test_reset_mid();
`ifdef WB_BYPASS_EN
    test_bypass();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
